// File: rtl/conv2d_stream_engine_pkg.sv
// Shared types and helpers for the streaming 2-D convolution engine:
// FSM state encoding, output-dimension arithmetic and the requantise/saturate step.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WRITE,
        FIN
    } state_t;

    // Working width for the requantiser; wide enough for any accumulator plus shifted bias.
    localparam int SAT_W = 64;

    function automatic int out_dim(input int in_sz, input int k, input int s, input int p);
        return (in_sz + 2*p - k) / s + 1;
    endfunction

    // Adds the bias at accumulator scale, floors back to data scale and clamps to dw bits.
    function automatic logic signed [SAT_W-1:0] sat_round(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] bias,
        input int                      frac,
        input int                      dw
    );
        logic signed [SAT_W-1:0] v;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        v  = (acc + (bias <<< frac)) >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv2d_stream_engine_addr_gen.sv
// Loop-nest counters (oy, ox, co outer; ci, ky, kx inner) and the zero-padding bounds check.
// Addresses are raw; the top gates them with the matching strobes.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IN_WIDTH    = 28,
    parameter int IN_HEIGHT   = 28,
    parameter int IN_CHANNEL  = 1,
    parameter int OUT_CHANNEL = 4,
    parameter int KER_WIDTH   = 3,
    parameter int KER_HEIGHT  = 3,
    parameter int STRIDE      = 1,
    parameter int PAD         = 0,
    parameter int ADR_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_tap_step,
    input  logic                 i_pix_step,
    output logic [ADR_WIDTH-1:0] o_in_adr,
    output logic [ADR_WIDTH-1:0] o_ker_adr,
    output logic [ADR_WIDTH-1:0] o_bias_adr,
    output logic [ADR_WIDTH-1:0] o_out_adr,
    output logic                 o_tap_valid,
    output logic                 o_first_tap,
    output logic                 o_last_tap,
    output logic                 o_last_pix
);

    localparam int OUT_W = out_dim(IN_WIDTH,  KER_WIDTH,  STRIDE, PAD);
    localparam int OUT_H = out_dim(IN_HEIGHT, KER_HEIGHT, STRIDE, PAD);
    localparam int CW    = 16;

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] KX_MAX = CW'(KER_WIDTH - 1);
    localparam logic [CW-1:0] KY_MAX = CW'(KER_HEIGHT - 1);
    localparam logic [CW-1:0] CI_MAX = CW'(IN_CHANNEL - 1);
    localparam logic [CW-1:0] CO_MAX = CW'(OUT_CHANNEL - 1);
    localparam logic [CW-1:0] OX_MAX = CW'(OUT_W - 1);
    localparam logic [CW-1:0] OY_MAX = CW'(OUT_H - 1);

    logic [CW-1:0] r_oy, r_ox, r_co, r_ci, r_ky, r_kx;
    logic signed [31:0] w_iy, w_ix, w_in_lin, w_ker_lin, w_out_lin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oy <= '0;
            r_ox <= '0;
            r_co <= '0;
            r_ci <= '0;
            r_ky <= '0;
            r_kx <= '0;
        end else if (i_clr) begin
            r_oy <= '0;
            r_ox <= '0;
            r_co <= '0;
            r_ci <= '0;
            r_ky <= '0;
            r_kx <= '0;
        end else begin
            // Tap counters wrap by themselves after the last tap, ready for the next pixel.
            if (i_tap_step) begin
                if (r_kx == KX_MAX) begin
                    r_kx <= '0;
                    if (r_ky == KY_MAX) begin
                        r_ky <= '0;
                        r_ci <= (r_ci == CI_MAX) ? '0 : r_ci + ONE;
                    end else begin
                        r_ky <= r_ky + ONE;
                    end
                end else begin
                    r_kx <= r_kx + ONE;
                end
            end
            if (i_pix_step) begin
                if (r_co == CO_MAX) begin
                    r_co <= '0;
                    if (r_ox == OX_MAX) begin
                        r_ox <= '0;
                        r_oy <= (r_oy == OY_MAX) ? '0 : r_oy + ONE;
                    end else begin
                        r_ox <= r_ox + ONE;
                    end
                end else begin
                    r_co <= r_co + ONE;
                end
            end
        end
    end

    always_comb begin
        w_iy      = $signed(32'(r_oy)) * STRIDE + $signed(32'(r_ky)) - PAD;
        w_ix      = $signed(32'(r_ox)) * STRIDE + $signed(32'(r_kx)) - PAD;
        w_in_lin  = (w_iy * IN_WIDTH + w_ix) * IN_CHANNEL + $signed(32'(r_ci));
        w_ker_lin = (($signed(32'(r_co)) * IN_CHANNEL + $signed(32'(r_ci))) * KER_HEIGHT
                    + $signed(32'(r_ky))) * KER_WIDTH + $signed(32'(r_kx));
        w_out_lin = ($signed(32'(r_oy)) * OUT_W + $signed(32'(r_ox))) * OUT_CHANNEL
                    + $signed(32'(r_co));
    end

    assign o_tap_valid = (w_iy >= 0) && (w_iy < IN_HEIGHT) && (w_ix >= 0) && (w_ix < IN_WIDTH);
    assign o_first_tap = (r_ci == '0) && (r_ky == '0) && (r_kx == '0);
    assign o_last_tap  = (r_ci == CI_MAX) && (r_ky == KY_MAX) && (r_kx == KX_MAX);
    assign o_last_pix  = (r_co == CO_MAX) && (r_ox == OX_MAX) && (r_oy == OY_MAX);

    assign o_in_adr   = ADR_WIDTH'(w_in_lin);
    assign o_ker_adr  = ADR_WIDTH'(w_ker_lin);
    assign o_bias_adr = ADR_WIDTH'(r_co);
    assign o_out_adr  = ADR_WIDTH'(w_out_lin);

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 2-D convolution layer engine: FSM, one-cycle read alignment, wide MAC,
// bias/requantise/saturate and optional ReLU on the write path.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int IN_WIDTH    = 28,
    parameter int IN_HEIGHT   = 28,
    parameter int IN_CHANNEL  = 1,
    parameter int OUT_CHANNEL = 4,
    parameter int KER_WIDTH   = 3,
    parameter int KER_HEIGHT  = 3,
    parameter int STRIDE      = 1,
    parameter int PAD         = 0,
    parameter int ADR_WIDTH   = 16,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_relu_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_in_rd,
    output logic [ADR_WIDTH-1:0]  o_in_adr,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_ker_rd,
    output logic [ADR_WIDTH-1:0]  o_ker_adr,
    input  logic [DATA_WIDTH-1:0] i_ker_data,
    output logic [ADR_WIDTH-1:0]  o_bias_adr,
    input  logic [DATA_WIDTH-1:0] i_bias_data,
    output logic                  o_out_wr,
    output logic [ADR_WIDTH-1:0]  o_out_adr,
    output logic [DATA_WIDTH-1:0] o_out_data
);

    state_t r_state, w_state_nxt;
    logic   w_clr, w_tap_step, w_pix_step;
    logic   w_tap_valid, w_first_tap, w_last_tap, w_last_pix;
    logic   w_mac, w_in_rd, w_write;
    logic   r_relu;
    logic [ADR_WIDTH-1:0] w_in_adr, w_ker_adr, w_bias_adr, w_out_adr;

    logic                           r_vld_p1, r_pix_ok_p1, r_first_p1;
    logic signed [DATA_WIDTH-1:0]   w_pix_p1, w_wgt_p1, w_bias;
    logic signed [2*DATA_WIDTH-1:0] w_prod_p1;
    logic signed [ACC_WIDTH-1:0]    w_acc_base, r_acc;
    logic signed [SAT_W-1:0]        w_sat, w_res;

    conv_addr_gen #(
        .IN_WIDTH    (IN_WIDTH),
        .IN_HEIGHT   (IN_HEIGHT),
        .IN_CHANNEL  (IN_CHANNEL),
        .OUT_CHANNEL (OUT_CHANNEL),
        .KER_WIDTH   (KER_WIDTH),
        .KER_HEIGHT  (KER_HEIGHT),
        .STRIDE      (STRIDE),
        .PAD         (PAD),
        .ADR_WIDTH   (ADR_WIDTH)
    ) u_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_clr),
        .i_tap_step  (w_tap_step),
        .i_pix_step  (w_pix_step),
        .o_in_adr    (w_in_adr),
        .o_ker_adr   (w_ker_adr),
        .o_bias_adr  (w_bias_adr),
        .o_out_adr   (w_out_adr),
        .o_tap_valid (w_tap_valid),
        .o_first_tap (w_first_tap),
        .o_last_tap  (w_last_tap),
        .o_last_pix  (w_last_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_relu  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && i_start) begin
                r_relu <= i_relu_en;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_tap_step  = 1'b0;
        w_pix_step  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = MAC;
                    w_clr       = 1'b1;
                end
            end
            MAC: begin
                w_tap_step = 1'b1;
                if (w_last_tap) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: w_state_nxt = WRITE;
            WRITE: begin
                w_pix_step  = 1'b1;
                w_state_nxt = w_last_pix ? FIN : MAC;
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_mac   = (r_state == MAC);
    assign w_write = (r_state == WRITE);
    // Padded taps never touch the input RAM; the weight is still fetched to keep the cadence.
    assign w_in_rd = w_mac && w_tap_valid;

    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == FIN);
    assign o_in_rd    = w_in_rd;
    assign o_in_adr   = w_in_rd ? w_in_adr : '0;
    assign o_ker_rd   = w_mac;
    assign o_ker_adr  = w_mac ? w_ker_adr : '0;
    assign o_bias_adr = w_bias_adr;
    assign o_out_wr   = w_write;
    assign o_out_adr  = w_write ? w_out_adr : '0;

    // ---- stage p0 -> p1: memory data returns one cycle after the tap was issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_pix_ok_p1 <= 1'b0;
            r_first_p1  <= 1'b0;
            r_acc       <= '0;
        end else begin
            r_vld_p1    <= w_mac;
            r_pix_ok_p1 <= w_in_rd;
            r_first_p1  <= w_mac && w_first_tap;
            if (r_vld_p1) begin
                r_acc <= w_acc_base + ACC_WIDTH'(w_prod_p1);
            end
        end
    end

    assign w_pix_p1   = r_pix_ok_p1 ? i_in_data : '0;
    assign w_wgt_p1   = i_ker_data;
    assign w_prod_p1  = w_pix_p1 * w_wgt_p1;
    assign w_acc_base = r_first_p1 ? '0 : r_acc;

    // ---- write stage: bias, requantise, saturate, ReLU
    assign w_bias     = i_bias_data;
    assign w_sat      = sat_round(SAT_W'(r_acc), SAT_W'(w_bias), FRAC_BITS, DATA_WIDTH);
    assign w_res      = (r_relu && w_sat[SAT_W-1]) ? '0 : w_sat;
    assign o_out_data = w_write ? w_res[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Bench for conv2d_stream_engine: four geometries share one set of memory models;
// a table of runs drives launches, a scoreboard queue holds the expected writes.
module tb_conv2d_stream_engine;

    // Geometry per instance: 4x4 plain, 4x4 padded, 5x5 stride 2, 3x3 Q8.8 with two filters.
    localparam int GW[4] = '{4, 4, 5, 3};
    localparam int GH[4] = '{4, 4, 5, 3};
    localparam int GS[4] = '{1, 1, 2, 1};
    localparam int GP[4] = '{0, 1, 0, 0};
    localparam int GC[4] = '{1, 1, 1, 2};
    localparam int GF[4] = '{0, 0, 0, 8};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic relu_en = 1'b0;
    logic start [4];
    logic busy [4], done [4], in_rd [4], ker_rd [4], out_wr [4];
    logic [15:0] in_adr [4], ker_adr [4], bias_adr [4], out_adr [4], out_data [4];
    logic [15:0] in_q [4], ker_q [4];

    logic signed [15:0] img  [64];
    logic signed [15:0] ker  [64];
    logic signed [15:0] bias [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        conv2d_stream_engine #(
            .DATA_WIDTH(16), .FRAC_BITS(GF[g]), .IN_WIDTH(GW[g]), .IN_HEIGHT(GH[g]),
            .IN_CHANNEL(1), .OUT_CHANNEL(GC[g]), .KER_WIDTH(3), .KER_HEIGHT(3),
            .STRIDE(GS[g]), .PAD(GP[g]), .ADR_WIDTH(16)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .i_start(start[g]), .i_relu_en(relu_en),
            .o_busy(busy[g]), .o_done(done[g]),
            .o_in_rd(in_rd[g]), .o_in_adr(in_adr[g]), .i_in_data(in_q[g]),
            .o_ker_rd(ker_rd[g]), .o_ker_adr(ker_adr[g]), .i_ker_data(ker_q[g]),
            .o_bias_adr(bias_adr[g]), .i_bias_data(bias[bias_adr[g][1:0]]),
            .o_out_wr(out_wr[g]), .o_out_adr(out_adr[g]), .o_out_data(out_data[g])
        );
    end

    // Synchronous memories; unread cycles return junk so a missing pad gate shows up.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            in_q[k]  <= in_rd[k]  ? img[in_adr[k][5:0]]  : 16'hDEAD;
            ker_q[k] <= ker_rd[k] ? ker[ker_adr[k][5:0]] : 16'hBEEF;
        end
    end

    typedef struct {
        int          dut;
        int          img_m;   // 0 ramp, 1 ones, 2 0x7FFF, 3 zero
        int          ker_m;   // 0 ones, 1 0x7FFF, 2 0x8001
        int          bias_m;  // 0 zero, 1 0x7FFF, 2 {+1.0, -1.0}
        bit          relu;
        int          n_wr;
        int          n_cyc;   // start cycle to done cycle, both inclusive
        int          n_live;  // taps with in_rd high
        logic [15:0] first;
        logic [15:0] last;
    } case_t;

    typedef struct {
        int          adr;
        logic [15:0] data;
        int          co;
    } exp_t;

    case_t cases [8];
    exp_t  sb [$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic load(input int im, input int km, input int bm);
        for (int i = 0; i < 64; i++) begin
            img[i] = (im == 0) ? 16'(i) : (im == 1) ? 16'sd1 : (im == 2) ? 16'sh7FFF : 16'sd0;
            ker[i] = (km == 0) ? 16'sd1 : (km == 1) ? 16'sh7FFF : 16'sh8001;
        end
        for (int i = 0; i < 4; i++) begin
            bias[i] = (bm == 1) ? 16'sh7FFF : 16'sd0;
        end
        if (bm == 2) begin
            bias[0] = 16'sh0100;
            bias[1] = 16'shFF00;
        end
    endtask

    function automatic logic [15:0] model(input int d, input int oy, input int ox,
                                          input int co, input bit relu);
        longint acc, v;
        acc = 0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                int iy, ix;
                longint px;
                iy = oy * GS[d] + ky - GP[d];
                ix = ox * GS[d] + kx - GP[d];
                px = (iy >= 0 && iy < GH[d] && ix >= 0 && ix < GW[d]) ? longint'(img[iy * GW[d] + ix]) : 0;
                acc += px * longint'(ker[co * 9 + ky * 3 + kx]);
            end
        end
        v = (acc + (longint'(bias[co]) <<< GF[d])) >>> GF[d];
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        if (relu && v < 0) v = 0;
        return v[15:0];
    endfunction

    task automatic run_case(input int idx, input bit poke);
        case_t c;
        exp_t  e;
        int    d, ow, oh, cyc, wr, live;
        bit    got_done;
        logic [15:0] first_d, last_d;
        c  = cases[idx];
        d  = c.dut;
        ow = (GW[d] + 2 * GP[d] - 3) / GS[d] + 1;
        oh = (GH[d] + 2 * GP[d] - 3) / GS[d] + 1;
        load(c.img_m, c.ker_m, c.bias_m);
        sb.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int co = 0; co < GC[d]; co++) begin
                    e.adr  = (oy * ow + ox) * GC[d] + co;
                    e.data = model(d, oy, ox, co, c.relu);
                    e.co   = co;
                    sb.push_back(e);
                end
        start[d] = 1'b1;
        relu_en  = c.relu;
        cyc = 1; wr = 0; live = 0; got_done = 1'b0;
        first_d = '0; last_d = '0;
        for (int t = 0; t < 2000 && !got_done; t++) begin
            @(posedge clk); #1;
            start[d] = poke && (t == 5);
            relu_en  = ~c.relu;
            cyc++;
            if (ker_rd[d] && in_rd[d]) live++;
            if (out_wr[d]) begin
                wr++;
                if (wr == 1) first_d = out_data[d];
                last_d = out_data[d];
                if (sb.size() == 0) begin
                    chk($sformatf("c%0d_extra_write", idx), 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("c%0d_out_adr", idx), out_adr[d], e.adr);
                    chk($sformatf("c%0d_out_data", idx), out_data[d], e.data);
                    chk($sformatf("c%0d_bias_adr", idx), bias_adr[d], e.co);
                end
            end
            if (done[d]) got_done = 1'b1;
        end
        chk($sformatf("c%0d_done_seen", idx), got_done, 1);
        chk($sformatf("c%0d_cycles", idx), cyc, c.n_cyc);
        chk($sformatf("c%0d_writes", idx), wr, c.n_wr);
        chk($sformatf("c%0d_live_taps", idx), live, c.n_live);
        chk($sformatf("c%0d_first", idx), first_d, c.first);
        chk($sformatf("c%0d_last", idx), last_d, c.last);
        chk($sformatf("c%0d_pending", idx), sb.size(), 0);
        @(posedge clk); #1;
        chk($sformatf("c%0d_idle_busy", idx), busy[d], 0);
        chk($sformatf("c%0d_idle_done", idx), done[d], 0);
    endtask

    initial begin
        int bad;
        cases[0] = '{0, 0, 0, 0, 1'b0,  4,  46,  36, 16'd45,    16'd90};
        cases[1] = '{1, 0, 0, 0, 1'b0, 16, 178, 100, 16'd10,    16'd50};
        cases[2] = '{2, 1, 0, 0, 1'b0,  4,  46,  36, 16'd9,     16'd9};
        cases[3] = '{3, 2, 1, 1, 1'b0,  2,  24,  18, 16'h7FFF,  16'h7FFF};
        cases[4] = '{3, 2, 2, 1, 1'b0,  2,  24,  18, 16'h8000,  16'h8000};
        cases[5] = '{3, 2, 2, 1, 1'b1,  2,  24,  18, 16'h0000,  16'h0000};
        cases[6] = '{3, 3, 0, 2, 1'b0,  2,  24,  18, 16'h0100,  16'hFF00};
        cases[7] = '{0, 0, 0, 0, 1'b1,  4,  46,  36, 16'd45,    16'd90};
        for (int k = 0; k < 4; k++) start[k] = 1'b0;
        load(0, 0, 0);

        #2;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_busy%0d", k), busy[k], 0);
            chk($sformatf("rst_outs%0d", k),
                {done[k], in_rd[k], ker_rd[k], out_wr[k]}, 0);
            chk($sformatf("rst_adrs%0d", k), {in_adr[k], ker_adr[k], out_adr[k], out_data[k]}, 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_case(i, 1'b0);

        // Abort mid-MAC with reset, then relaunch: nothing may be written by the aborted run.
        load(0, 0, 0);
        start[0] = 1'b1;
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            start[0] = 1'b0;
            if (out_wr[0]) bad++;
        end
        chk("abort_was_busy", busy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_low", busy[0], 0);
        chk("abort_ker_rd_low", ker_rd[0], 0);
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (out_wr[0] || done[0] || busy[0]) bad++;
        end
        chk("abort_no_activity", bad, 0);
        run_case(0, 1'b0);

        // A start pulse in the middle of a run must not restart or disturb it.
        run_case(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
